// File: rtl/prog_loader_if.sv
// Program-loader bus: byte-stream load handshake, CPU fetch port and status flags.
interface prog_loader_if;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic [3:0] adr;
    logic [7:0] dout;
    logic       cpu_run;
    logic       loading;
    logic       ld_done;
    logic       ld_err;

    modport master (
        output ld_start, ld_valid, ld_data, adr,
        input  ld_ready, dout, cpu_run, loading, ld_done, ld_err
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, adr,
        output ld_ready, dout, cpu_run, loading, ld_done, ld_err
    );
endinterface

// File: rtl/prog_loader.sv
// 16-byte program store filled from a byte stream with optional trailing
// checksum; gates cpu_run until a complete, verified image is present.
module prog_loader #(
    parameter bit CHK_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    prog_loader_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERR} state_t;

    state_t     state, state_nxt;
    logic [3:0] wptr;
    logic [7:0] sum;
    logic [7:0] mem [16];
    logic       accept_st;
    logic       xfer;
    logic       wr_en;
    logic       restart;
    logic       done_nxt;
    logic       cpu_run_p1;
    logic       ld_done_p1;
    logic       ld_err_p1;

    function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    assign accept_st   = (state == LOAD) || (state == CHECK);
    assign bus.ld_ready = accept_st;
    assign bus.loading  = accept_st;
    assign bus.dout     = mem[bus.adr];
    assign bus.cpu_run  = cpu_run_p1;
    assign bus.ld_done  = ld_done_p1;
    assign bus.ld_err   = ld_err_p1;
    assign xfer         = bus.ld_valid & accept_st;

    // ld_start outranks any transfer in the same cycle, so that byte is dropped.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        restart   = 1'b0;
        done_nxt  = 1'b0;
        if (bus.ld_start) begin
            restart   = 1'b1;
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer) begin
                        wr_en = 1'b1;
                        if (wptr == 4'd15) begin
                            if (CHK_EN) begin
                                state_nxt = CHECK;
                            end else begin
                                state_nxt = RUN;
                                done_nxt  = 1'b1;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        if (add_mod256(sum, bus.ld_data) == 8'h00) begin
                            state_nxt = RUN;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ERR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: status flags registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cpu_run_p1 <= 1'b0;
            ld_done_p1 <= 1'b0;
            ld_err_p1  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cpu_run_p1 <= (state_nxt == RUN);
            ld_done_p1 <= done_nxt;
            ld_err_p1  <= (state_nxt == ERR);
        end
    end

    // The pointer wraps 15->0 only on the transfer that leaves LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= 4'd0;
            sum  <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (restart) begin
            wptr <= 4'd0;
            sum  <= 8'h00;
        end else if (wr_en) begin
            mem[wptr] <= bus.ld_data;
            sum       <= add_mod256(sum, bus.ld_data);
            wptr      <= wptr + 4'd1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: stimulus queues expected snapshots/events,
// a monitor pops them on ld_done, ld_err rise, or pending snapshot requests.
module tb_prog_loader;

    typedef enum logic [1:0] {K_SNAP, K_DONE, K_ERR} kind_t;
    typedef struct {
        kind_t            kind;
        int               sel;
        string            name;
        logic [15:0][7:0] img;
        logic [4:0]       f;     // {cpu_run, ld_ready, loading, ld_done, ld_err}
    } exp_t;

    localparam logic [4:0] F_IDLE = 5'b00000;
    localparam logic [4:0] F_LOAD = 5'b01100;
    localparam logic [4:0] F_RUN  = 5'b10000;
    localparam logic [4:0] F_DONE = 5'b10010;
    localparam logic [4:0] F_ERR  = 5'b00001;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q[$];
    logic [15:0][7:0] mem_m [2];
    int   wp [2];
    logic [1:0] err_prev = 2'b00;

    prog_loader_if bus_c();
    prog_loader_if bus_n();

    prog_loader #(.CHK_EN(1'b1)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
    prog_loader #(.CHK_EN(1'b0)) u_dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    always #50 clk = ~clk;

    wire [1:0] done_v = {bus_n.ld_done, bus_c.ld_done};
    wire [1:0] err_v  = {bus_n.ld_err,  bus_c.ld_err};

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", nm, act, exp_v);
    endtask

    function automatic logic [4:0] flags(input int s);
        if (s == 0) return {bus_c.cpu_run, bus_c.ld_ready, bus_c.loading, bus_c.ld_done, bus_c.ld_err};
        return {bus_n.cpu_run, bus_n.ld_ready, bus_n.loading, bus_n.ld_done, bus_n.ld_err};
    endfunction

    function automatic logic ready(input int s);
        return (s == 0) ? bus_c.ld_ready : bus_n.ld_ready;
    endfunction

    task automatic rd(input int s, input int a, output logic [7:0] d);
        if (s == 0) begin bus_c.adr = 4'(a); #1; d = bus_c.dout; end
        else begin bus_n.adr = 4'(a); #1; d = bus_n.dout; end
    endtask

    task automatic compare(input exp_t e);
        logic [4:0] f;
        logic [7:0] d;
        string fn [5] = '{"cpu_run", "ld_ready", "loading", "ld_done", "ld_err"};
        f = flags(e.sel);
        for (int b = 0; b < 5; b++)
            chk($sformatf("%s %s", e.name, fn[b]), 8'(f[4-b]), 8'(e.f[4-b]));
        for (int a = 0; a < 16; a++) begin
            rd(e.sel, a, d);
            chk($sformatf("%s mem[%0d]", e.name, a), d, e.img[a]);
        end
    endtask

    // Monitor: one pop per falling edge, DUT events first, then pending snapshots.
    initial begin
        int    ev_s;
        kind_t ev_k;
        exp_t  e;
        bus_c.adr = 4'd0;
        bus_n.adr = 4'd0;
        forever begin
            @(negedge clk);
            ev_s = -1;
            ev_k = K_SNAP;
            for (int s = 0; s < 2; s++) begin
                if (ev_s < 0 && done_v[s]) begin ev_s = s; ev_k = K_DONE; end
                else if (ev_s < 0 && err_v[s] && !err_prev[s]) begin ev_s = s; ev_k = K_ERR; end
            end
            err_prev = err_v;
            if (ev_s >= 0) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_event: got kind %0d on dut %0d, required none", ev_k, ev_s);
                end else begin
                    e = q.pop_front();
                    chk({e.name, " kind"}, 8'(ev_k), 8'(e.kind));
                    chk({e.name, " dut"}, 8'(ev_s), 8'(e.sel));
                    compare(e);
                end
            end else if (q.size() > 0 && q[0].kind == K_SNAP) begin
                e = q.pop_front();
                compare(e);
            end
        end
    end

    task automatic push(input kind_t k, input int s, input string nm,
                        input logic [15:0][7:0] im, input logic [4:0] f);
        exp_t e;
        e.kind = k; e.sel = s; e.name = nm; e.img = im; e.f = f;
        q.push_back(e);
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 40 && q.size() > 0; k++) begin
            @(negedge clk); #20;
        end
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL queue_drain: got %0d pending (next %s), required 0", q.size(), q[0].name);
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic drive(input int s, input logic st, input logic v, input logic [7:0] d);
        if (s == 0) begin bus_c.ld_start = st; bus_c.ld_valid = v; bus_c.ld_data = d; end
        else begin bus_n.ld_start = st; bus_n.ld_valid = v; bus_n.ld_data = d; end
    endtask

    task automatic idle(input int s, input int n);
        drive(s, 1'b0, 1'b0, 8'hEE);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start(input int s);
        drive(s, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        drive(s, 1'b0, 1'b0, 8'hEE);
        wp[s] = 0;
    endtask

    task automatic send(input int s, input logic [7:0] b, input bit wr);
        logic r;
        r = 1'b0;
        drive(s, 1'b0, 1'b1, b);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); r = ready(s);
            @(posedge clk); #1;
            if (r) break;
        end
        if (!r) begin
            n_chk++;
            $display("FAIL send_timeout: dut %0d byte %02h got no ld_ready, required ready", s, b);
        end else if (wr && wp[s] < 16) begin
            mem_m[s][wp[s]] = b;
            wp[s]++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][7:0] img;
        int n;
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        mem_m[0] = '0; mem_m[1] = '0; wp[0] = 0; wp[1] = 0;
        #10 rst_n = 1'b0;
        push(K_SNAP, 0, "in_reset_c", '0, F_IDLE);
        push(K_SNAP, 1, "in_reset_n", '0, F_IDLE);
        wait_empty();
        rst_n = 1'b1;
        idle(0, 2);
        push(K_SNAP, 0, "post_reset_c", '0, F_IDLE);
        push(K_SNAP, 1, "post_reset_n", '0, F_IDLE);
        wait_empty();

        // A byte offered in IDLE must be ignored.
        drive(0, 1'b0, 1'b1, 8'h5A);
        repeat (3) begin @(posedge clk); #1; end
        drive(0, 1'b0, 1'b0, 8'hEE);
        push(K_SNAP, 0, "idle_hold", '0, F_IDLE);
        wait_empty();

        // 01..10 sums to 0x88; checksum 0x78 completes to 0x100.
        start(0);
        for (int i = 0; i < 16; i++) send(0, 8'(i + 1), 1'b1);
        push(K_DONE, 0, "load_ok", mem_m[0], F_DONE);
        send(0, 8'h78, 1'b0);
        drive(0, 1'b0, 1'b0, 8'hEE);
        push(K_SNAP, 0, "run_state", mem_m[0], F_RUN);
        wait_empty();

        // 20..2F sums to 0x78; checksum 0x77 gives 0xEF, a mismatch.
        start(0);
        push(K_SNAP, 0, "restart_from_run", mem_m[0], F_LOAD);
        wait_empty();
        for (int i = 0; i < 16; i++) begin
            send(0, 8'(8'h20 + i), 1'b1);
            n = int'($urandom_range(0, 2));
            if (n > 0) idle(0, n);
        end
        push(K_ERR, 0, "bad_chk", mem_m[0], F_ERR);
        send(0, 8'h77, 1'b0);
        drive(0, 1'b0, 1'b0, 8'hEE);
        push(K_SNAP, 0, "err_state", mem_m[0], F_ERR);
        wait_empty();
        start(0);
        push(K_SNAP, 0, "err_cleared", mem_m[0], F_LOAD);
        wait_empty();

        // Seven bytes, then ld_start with 0xAA offered: 0xAA is neither stored nor summed.
        for (int i = 0; i < 7; i++) send(0, 8'(8'hF1 + i), 1'b1);
        drive(0, 1'b1, 1'b1, 8'hAA);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'hEE);
        wp[0] = 0;
        push(K_SNAP, 0, "restart_aa", mem_m[0], F_LOAD);
        wait_empty();
        for (int i = 0; i < 16; i++) send(0, 8'(i + 1), 1'b1);
        push(K_DONE, 0, "reload_ok", mem_m[0], F_DONE);
        send(0, 8'h78, 1'b0);
        drive(0, 1'b0, 1'b0, 8'hEE);
        wait_empty();

        // Reset mid-load, between clock edges, with a byte still offered.
        start(0);
        for (int i = 0; i < 10; i++) send(0, 8'(8'h50 + i), 1'b1);
        drive(0, 1'b0, 1'b1, 8'h5A);
        rst_n = 1'b0;
        mem_m[0] = '0; mem_m[1] = '0; wp[0] = 0; wp[1] = 0;
        push(K_SNAP, 0, "reset_mid_c", '0, F_IDLE);
        push(K_SNAP, 1, "reset_mid_n", '0, F_IDLE);
        wait_empty();
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(K_SNAP, 0, "post_release", '0, F_IDLE);
        wait_empty();
        drive(0, 1'b0, 1'b0, 8'hEE);

        // No-checksum instance: the 16th byte finishes the load.
        for (int i = 0; i < 16; i++) img[i] = 8'(8'h61 + i);
        start(1);
        push(K_DONE, 1, "nochk_ok", img, F_DONE);
        for (int i = 0; i < 16; i++) send(1, 8'(8'h61 + i), 1'b1);
        drive(1, 1'b0, 1'b0, 8'hEE);
        push(K_SNAP, 1, "nochk_run", mem_m[1], F_RUN);
        wait_empty();

        idle(0, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
